// File: rtl/text_console_writer.sv
// Character-RAM writer for the VGA text console: turns an ASCII byte stream
// into glyph base addresses at a cursor, with wrap, row clear and screen clear.
module text_console_writer #(
  parameter int          COLS        = 40,
  parameter int          ROWS        = 15,
  parameter logic [7:0]  BLANK_CODE  = 8'h20,
  parameter int          GLYPH_SHIFT = 5
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [7:0]  iData,
  input  logic        iValid,
  output logic        oReady,
  output logic        oWrEn,
  output logic [9:0]  oWrAddr,
  output logic [11:0] oWrData,
  output logic [5:0]  oCursorCol,
  output logic [3:0]  oCursorRow,
  output logic        oBusy
);

  // state     | meaning
  // ST_IDLE   | accepting bytes, cursor valid
  // ST_CLRALL | blanking all cells 0..COLS*ROWS-1, one per cycle
  // ST_CLRROW | blanking the row the cursor has just moved onto
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLRALL = 2'd1,
    ST_CLRROW = 2'd2
  } state_t;

  localparam logic [9:0]  CELLS    = 10'(COLS * ROWS);
  localparam logic [9:0]  ROW_LEN  = 10'(COLS);
  localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
  localparam logic [3:0]  LAST_ROW = 4'(ROWS - 1);

  localparam logic [7:0]  CH_BS = 8'h08;
  localparam logic [7:0]  CH_LF = 8'h0A;
  localparam logic [7:0]  CH_FF = 8'h0C;
  localparam logic [7:0]  CH_CR = 8'h0D;

  function automatic logic [11:0] glyph_addr(input logic [7:0] code);
    return 12'(code[6:0]) << GLYPH_SHIFT;
  endfunction

  function automatic logic [9:0] row_base(input logic [3:0] row);
    return 10'(row) * ROW_LEN;
  endfunction

  localparam logic [11:0] BLANK_GLYPH = 12'(BLANK_CODE[6:0]) << GLYPH_SHIFT;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [5:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;
  logic        wr_en_q, wr_en_d;
  logic [9:0]  addr_q, addr_d;
  logic [11:0] data_q, data_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        printable;
  logic [3:0]  next_row;
  logic [9:0]  cur_base;

  assign accept    = (state_q == ST_IDLE) && iValid && ready_q;
  assign printable = (iData >= 8'h20) && (iData <= 8'h7E);
  assign next_row  = (row_q == LAST_ROW) ? 4'd0 : row_q + 4'd1;
  assign cur_base  = row_base(row_q);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_CLRALL;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = ready_q;
    busy_d  = busy_q;

    unique case (state_q)
      ST_CLRALL: begin
        if (cnt_q == CELLS) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          data_d  = BLANK_GLYPH;
          cnt_d   = cnt_q + 10'd1;
        end
      end

      ST_CLRROW: begin
        if (cnt_q == ROW_LEN) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = cur_base + cnt_q;
          data_d  = BLANK_GLYPH;
          cnt_d   = cnt_q + 10'd1;
        end
      end

      ST_IDLE: begin
        if (accept) begin
          if (printable) begin
            wr_en_d = 1'b1;
            addr_d  = cur_base + 10'(col_q);
            data_d  = glyph_addr(iData);
            if (col_q == LAST_COL) begin
              // Wrapping onto a new line also blanks it before more text lands
              col_d   = '0;
              row_d   = next_row;
              state_d = ST_CLRROW;
              cnt_d   = '0;
              ready_d = 1'b0;
              busy_d  = 1'b1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else begin
            unique case (iData)
              CH_CR: col_d = '0;
              CH_LF: begin
                col_d   = '0;
                row_d   = next_row;
                state_d = ST_CLRROW;
                cnt_d   = '0;
                ready_d = 1'b0;
                busy_d  = 1'b1;
              end
              CH_BS: begin
                if (col_q != 6'd0) begin
                  col_d   = col_q - 6'd1;
                  wr_en_d = 1'b1;
                  addr_d  = cur_base + 10'(col_q) - 10'd1;
                  data_d  = BLANK_GLYPH;
                end
              end
              CH_FF: begin
                col_d   = '0;
                row_d   = '0;
                state_d = ST_CLRALL;
                cnt_d   = '0;
                ready_d = 1'b0;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        state_d = ST_CLRALL;
        cnt_d   = '0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign oReady     = ready_q;
  assign oWrEn      = wr_en_q;
  assign oWrAddr    = addr_q;
  assign oWrData    = data_q;
  assign oCursorCol = col_q;
  assign oCursorRow = row_q;
  assign oBusy      = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a console model predicts every RAM
// write and cursor move; a monitor pops and compares each observed write.
module tb_text_console_writer;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [7:0]  iData = 8'h00;
  logic        iValid = 1'b0;
  logic        oReady, oWrEn, oBusy;
  logic [9:0]  oWrAddr;
  logic [11:0] oWrData;
  logic [5:0]  oCursorCol;
  logic [3:0]  oCursorRow;

  text_console_writer dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid),
    .oReady(oReady), .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oCursorCol(oCursorCol), .oCursorRow(oCursorRow), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int passed = 0;
  logic [21:0] exp_q[$];
  int m_col = 0;
  int m_row = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic push_wr(input int addr, input int data);
    exp_q.push_back({10'(addr), 12'(data)});
  endtask

  task automatic push_row_clear(input int row);
    for (int c = 0; c < 40; c++) push_wr(row * 40 + c, 12'h400);
  endtask

  task automatic push_screen_clear();
    for (int a = 0; a < 600; a++) push_wr(a, 12'h400);
  endtask

  // Console semantics: returns how many edges after acceptance oReady stays low (0 = none).
  task automatic model_accept(input logic [7:0] b, output int clr);
    clr = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_row * 40 + m_col, int'(b[6:0]) * 32);
      if (m_col == 39) begin
        m_col = 0;
        m_row = (m_row + 1) % 15;
        push_row_clear(m_row);
        clr = 41;
      end else m_col++;
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 15;
      push_row_clear(m_row);
      clr = 41;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row * 40 + m_col, 12'h400);
      end
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      push_screen_clear();
      clr = 601;
    end
  endtask

  always @(negedge iClk) begin
    if (!iRst && oWrEn) begin
      if (exp_q.size() == 0) chk("unexpected_write", int'(oWrAddr), -1);
      else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(oWrAddr), int'(e[21:12]));
        chk("wr_data", int'(oWrData), int'(e[11:0]));
      end
    end
  end

  task automatic wait_ready(input string nm, input int expected);
    int n = 0;
    do begin
      @(posedge iClk); #1;
      n++;
    end while (!oReady && n < 2000);
    chk(nm, n, expected);
    chk({nm, "_busy"}, int'(oBusy), 0);
  endtask

  // keep: leave iValid high for a back-to-back follower; wait_clr: time the clear.
  task automatic send(input logic [7:0] b, input bit keep = 0, input bit wait_clr = 1);
    int waited = 0;
    int clr;
    @(negedge iClk);
    iData = b;
    iValid = 1'b1;
    while (!oReady && waited < 2000) begin
      @(negedge iClk);
      waited++;
    end
    if (!oReady) begin
      chk("handshake_timeout", waited, 0);
      iValid = 1'b0;
      return;
    end
    @(posedge iClk);
    model_accept(b, clr);
    #1;
    chk("cursor_col", int'(oCursorCol), m_col);
    chk("cursor_row", int'(oCursorRow), m_row);
    chk("ready_after_accept", int'(oReady), (clr == 0) ? 1 : 0);
    iValid = keep && (clr == 0);
    if (clr != 0 && wait_clr) wait_ready("clear_len", clr);
  endtask

  task automatic check_reset_vals();
    chk("rst_wren", int'(oWrEn), 0);
    chk("rst_addr", int'(oWrAddr), 0);
    chk("rst_data", int'(oWrData), 0);
    chk("rst_ready", int'(oReady), 0);
    chk("rst_busy", int'(oBusy), 1);
    chk("rst_col", int'(oCursorCol), 0);
    chk("rst_row", int'(oCursorRow), 0);
  endtask

  task automatic release_reset();
    m_col = 0;
    m_row = 0;
    exp_q.delete();
    push_screen_clear();
    @(negedge iClk);
    iRst = 1'b0;
    wait_ready("init_len", 601);
    chk("init_col", int'(oCursorCol), 0);
    chk("init_row", int'(oCursorRow), 0);
  endtask

  task automatic send_other();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255));
    while ((v >= 8'h20 && v <= 8'h7E) || v == 8'h08 || v == 8'h0A || v == 8'h0C || v == 8'h0D);
    send(v, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    #1;
    check_reset_vals();
    release_reset();

    send(8'h41, 1);
    send(8'h42);

    send(8'h0D);
    for (int i = 0; i < 40; i++) send(8'(8'h30 + (i % 40)), 1);
    chk("wrap_col", int'(oCursorCol), 0);
    chk("wrap_row", int'(oCursorRow), 1);

    for (int i = 0; i < 13; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61, 1);
    send(8'h0A);

    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h62, 1);
    send(8'h0D);
    send(8'h08);
    for (int i = 0; i < 4; i++) send(8'h63, 1);
    send(8'h08);

    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h7E, 1);
    send(8'h0C);
    send(8'h01, 1);
    send(8'h7F, 1);
    send(8'h9B);

    // Reset landing on the 20th write of a row clear
    begin
      int seen = 0;
      int guard = 0;
      send(8'h0A, 0, 0);
      while (seen < 20 && guard < 200) begin
        @(posedge iClk); #1;
        guard++;
        if (oWrEn) seen++;
      end
      chk("rowclr_writes_before_rst", seen, 20);
      iRst = 1'b1;
      @(posedge iClk); #1;
      check_reset_vals();
      @(posedge iClk); #1;
      release_reset();
    end

    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 70) send(8'($urandom_range(8'h20, 8'h7E)), 1'($urandom_range(0, 1)));
      else if (r < 78) send(8'h08, 1'($urandom_range(0, 1)));
      else if (r < 84) send(8'h0D, 1'($urandom_range(0, 1)));
      else if (r < 90) send(8'h0A);
      else if (r < 97) send_other();
      else send(8'h0C);
    end

    @(negedge iClk);
    iValid = 1'b0;
    repeat (5) @(posedge iClk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

endmodule
